// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
//   Load/store bus between the pipeline MEMORY stage (master) and the data
//   memory responder (slave).
//
//   Request channel  (master -> slave, valid/ready):
//     req_valid, req_write, req_addr[15:0], req_wdata[DATA_W-1:0]; req_ready back
//   Response channel (slave -> master, valid/ready):
//     resp_valid, resp_rdata[DATA_W-1:0], resp_err; resp_ready back
//   Pipeline control:
//     stall        slave -> master, freeze request while an access is open
//     perr_inject  master -> slave, test-only parity corruption on stores
// -----------------------------------------------------------------------------
interface dmem_responder_if #(
   parameter int unsigned DATA_W = 32
);

   logic              req_valid;
   logic              req_write;
   logic [15:0]       req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              req_ready;

   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;

   logic              stall;
   logic              perr_inject;

   modport master (
      output req_valid,
      output req_write,
      output req_addr,
      output req_wdata,
      input  req_ready,
      input  resp_valid,
      output resp_ready,
      input  resp_rdata,
      input  resp_err,
      input  stall,
      output perr_inject
   );

   modport slave (
      input  req_valid,
      input  req_write,
      input  req_addr,
      input  req_wdata,
      output req_ready,
      output resp_valid,
      input  resp_ready,
      output resp_rdata,
      output resp_err,
      output stall,
      input  perr_inject
   );

endinterface

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Slave end of the MEMORY stage load/store interface. Accepts one request at
//   a time, services it from an internal word-addressed RAM after LATENCY
//   cycles, and returns the result over a valid/ready response handshake.
//   While a request is open the stall output freezes the pipeline.
//
//   Parameters:
//     ADDR_W   RAM word-address width (depth = 2**ADDR_W), 1..16
//     DATA_W   data word width
//     LATENCY  accept-to-response latency in cycles, 1..15
//
//   Ports:
//     clk   system clock, rising edge
//     rst   synchronous active-high reset (RAM contents are kept)
//     bus   dmem_responder_if.slave: request channel, response channel,
//           stall and perr_inject
//
//   Build option:
//     DMEM_PARITY_EN  when defined, every RAM word carries an even-parity bit.
//                     perr_inject on a captured store inverts the stored bit;
//                     a load with a parity mismatch reports resp_err while
//                     still returning the raw stored data. When undefined,
//                     perr_inject is ignored and resp_err is the range check.
// -----------------------------------------------------------------------------
module dmem_responder #(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned LATENCY = 2
) (
   input logic             clk,
   input logic             rst,
   dmem_responder_if.slave bus
);

   localparam int unsigned DEPTH    = 2 ** ADDR_W;
   localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

   // --------------------------------------------------------------------------
   // Elaboration-time parameter checks
   // --------------------------------------------------------------------------
   generate
      if ((LATENCY < 1) || (LATENCY > 15)) begin : g_bad_latency
         $error("dmem_responder: LATENCY must be in 1..15");
      end
      if ((ADDR_W < 1) || (ADDR_W > 16)) begin : g_bad_addr_w
         $error("dmem_responder: ADDR_W must be in 1..16");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // --------------------------------------------------------------------------
   // State and captured request
   // --------------------------------------------------------------------------
   state_t            r_state;
   state_t            w_state_nxt;
   logic [3:0]        r_cnt;
   logic              r_write;
   logic [15:0]       r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_perr;

   // Response registers, loaded on the commit edge and held through RESP
   logic [DATA_W-1:0] r_rdata;
   logic              r_err;

   // RAM
   logic [DATA_W-1:0] r_mem [DEPTH];

   // Combinational control
   logic              w_accept;
   logic              w_commit;
   logic              w_req_ready;
   logic              w_resp_valid;
   logic              w_stall;

   // Access source: live bus inputs or captured request
   logic              w_src_write;
   logic [15:0]       w_src_addr;
   logic [DATA_W-1:0] w_src_wdata;
   logic              w_src_perr;
   logic [ADDR_W-1:0] w_idx;
   logic              w_oor;
   logic [DATA_W-1:0] w_rd_word;
   logic              w_par_bad;
   logic [DATA_W-1:0] w_resp_data;
   logic              w_resp_err;

   // --------------------------------------------------------------------------
   // Next-state and handshake outputs
   // --------------------------------------------------------------------------
   always_comb begin
      w_state_nxt  = r_state;
      w_accept     = 1'b0;
      w_req_ready  = 1'b0;
      w_resp_valid = 1'b0;
      w_stall      = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_req_ready = 1'b1;
            if (bus.req_valid) begin
               w_accept    = 1'b1;
               w_stall     = 1'b1;
               w_state_nxt = (LATENCY == 1) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            w_stall = 1'b1;
            if (r_cnt == 4'd1) begin
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            w_resp_valid = 1'b1;
            if (bus.resp_ready) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_stall = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // The RAM access happens on the edge that enters RESP. With LATENCY==1
   // that is the accept edge itself, so the request must come straight from
   // the bus rather than from the capture registers.
   assign w_commit    = (r_state != ST_RESP) && (w_state_nxt == ST_RESP) && !rst;
   assign w_src_write = (r_state == ST_IDLE) ? bus.req_write   : r_write;
   assign w_src_addr  = (r_state == ST_IDLE) ? bus.req_addr    : r_addr;
   assign w_src_wdata = (r_state == ST_IDLE) ? bus.req_wdata   : r_wdata;
   assign w_src_perr  = (r_state == ST_IDLE) ? bus.perr_inject : r_perr;
   assign w_idx       = w_src_addr[ADDR_W-1:0];

   // --------------------------------------------------------------------------
   // Address range check: any set bit above the RAM index is out of range
   // --------------------------------------------------------------------------
   generate
      if (ADDR_W < 16) begin : g_range
         assign w_oor = |w_src_addr[15:ADDR_W];
      end else begin : g_no_range
         assign w_oor = 1'b0;
      end
   endgenerate

   assign w_rd_word = r_mem[w_idx];

   // --------------------------------------------------------------------------
   // Optional parity store
   // --------------------------------------------------------------------------
`ifdef DMEM_PARITY_EN
   logic r_par [DEPTH];

   always_ff @(posedge clk) begin
      if (w_commit && w_src_write && !w_oor) begin
         r_par[w_idx] <= (^w_src_wdata) ^ w_src_perr;
      end
   end

   // Only loads check parity; a store response reports the range check alone
   assign w_par_bad = !w_src_write && ((^w_rd_word) != r_par[w_idx]);
`else
   logic w_unused_perr;

   assign w_unused_perr = w_src_perr;
   assign w_par_bad     = 1'b0;
`endif

   // Out-of-range accesses return zero data for both loads and stores
   always_comb begin
      w_resp_data = '0;
      w_resp_err  = w_oor | w_par_bad;
      if (!w_oor) begin
         w_resp_data = w_src_write ? w_src_wdata : w_rd_word;
      end
   end

   // --------------------------------------------------------------------------
   // RAM write port; contents survive reset
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_commit && w_src_write && !w_oor) begin
         r_mem[w_idx] <= w_src_wdata;
      end
   end

   // --------------------------------------------------------------------------
   // State, counter, capture and response registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_write <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_perr  <= 1'b0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;

         if (w_accept) begin
            r_cnt   <= CNT_LOAD;
            r_write <= bus.req_write;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_perr  <= bus.perr_inject;
         end else if (r_state == ST_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
         end

         if (w_commit) begin
            r_rdata <= w_resp_data;
            r_err   <= w_resp_err;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign bus.req_ready  = w_req_ready;
   assign bus.resp_valid = w_resp_valid;
   assign bus.resp_rdata = r_rdata;
   assign bus.resp_err   = r_err;
   assign bus.stall      = w_stall;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Scoreboard bench for dmem_responder. The driver pushes the expected
//   response of every accepted request (from an array-based memory model) into
//   a queue; an independent monitor pops and compares on each response
//   handshake and also checks accept-to-valid latency.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

   localparam int unsigned ADDR_W  = 10;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned LATENCY = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   dmem_responder_if #(.DATA_W(DATA_W)) bus ();

   dmem_responder #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .LATENCY(LATENCY)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          acc_cyc;
   } exp_t;

   exp_t        sb_q[$];
   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;
   int          cyc    = 0;
   int          stall_cnt = 0;

   // Reference memory: word contents and "stored with corrupted parity" flag
   logic [31:0] ref_mem [int];
   bit          ref_bad [int];

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (!rst && bus.stall) stall_cnt <= stall_cnt + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic timeout(input string name);
      n_chk++;
      $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
   endtask

   // Behavioural model of one access
   function automatic exp_t model_access(input bit wr, input logic [15:0] a,
                                         input logic [31:0] d, input bit perr);
      exp_t e;
      e.acc_cyc = cyc;
      if ((a >> ADDR_W) != 16'd0) begin
         e.rdata = 32'd0;
         e.err   = 1'b1;
      end else if (wr) begin
         ref_mem[int'(a)] = d;
         ref_bad[int'(a)] = perr;
         e.rdata = d;
         e.err   = 1'b0;
      end else begin
         e.rdata = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'd0;
`ifdef DMEM_PARITY_EN
         e.err   = ref_bad.exists(int'(a)) ? ref_bad[int'(a)] : 1'b0;
`else
         e.err   = 1'b0;
`endif
      end
      return e;
   endfunction

   // Present a request and hold it until accepted. Returns at posedge+1 after
   // the accept edge. With push=0 the model is left untouched.
   task automatic issue(input bit wr, input logic [15:0] a, input logic [31:0] d,
                        input bit perr, input bit push);
      bit ok;
      ok = 1'b0;
      bus.req_valid   = 1'b1;
      bus.req_write   = wr;
      bus.req_addr    = a;
      bus.req_wdata   = d;
      bus.perr_inject = perr;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (bus.req_ready) begin
            if (push) sb_q.push_back(model_access(wr, a, d, perr));
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk); #1;
      bus.req_valid   = 1'b0;
      bus.perr_inject = 1'b0;
      if (!ok) timeout("req_accept");
   endtask

   // Wait for the response handshake; optionally randomise resp_ready
   task automatic wait_done(input bit rand_rr);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.resp_valid && bus.resp_ready) begin
            done = 1'b1;
            break;
         end
         @(posedge clk); #1;
         if (rand_rr) bus.resp_ready = (i > 8) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      if (!done) timeout("resp_handshake");
   endtask

   // Monitor: latency on each rising resp_valid, data/err on each handshake
   initial begin : monitor
      bit   prev_v;
      exp_t e;
      prev_v = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_v = 1'b0;
         end else begin
            if (bus.resp_valid && !prev_v) begin
               if (sb_q.size() == 0) begin
                  n_chk++;
                  $display("FAIL unexpected_resp: resp_valid with empty scoreboard (t=%0t)", $time);
               end else begin
                  check("latency", 64'(cyc - sb_q[0].acc_cyc), 64'(LATENCY));
               end
            end
            if (bus.resp_valid && bus.resp_ready && sb_q.size() != 0) begin
               e = sb_q.pop_front();
               check("resp_rdata", 64'(bus.resp_rdata), 64'(e.rdata));
               check("resp_err", 64'(bus.resp_err), 64'(e.err));
            end
            prev_v = bus.resp_valid;
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", n_pass, n_chk + 1);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int          s0;
      bit          wr;
      logic [15:0] a;
      logic [31:0] d;

      bus.req_valid   = 1'b0;
      bus.req_write   = 1'b0;
      bus.req_addr    = '0;
      bus.req_wdata   = '0;
      bus.resp_ready  = 1'b1;
      bus.perr_inject = 1'b0;

      // 1. Reset then idle
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_req_ready",  64'(bus.req_ready),  64'd1);
      check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      check("rst_resp_rdata", 64'(bus.resp_rdata), 64'd0);
      check("rst_resp_err",   64'(bus.resp_err),   64'd0);
      check("rst_stall",      64'(bus.stall),      64'd0);
      @(posedge clk); #1;

      // Prefill the low words so every later read has a defined model value
      for (int i = 0; i < 16; i++) begin
         issue(1'b1, 16'(i), (i == 0) ? 32'd0 : 32'(i) * 32'h01010101, 1'b0, 1'b1);
         wait_done(1'b0);
      end

      // 2. Store then load with resp_ready high; stall lasts LATENCY cycles
      s0 = stall_cnt;
      issue(1'b1, 16'h0005, 32'hDEADBEEF, 1'b0, 1'b1);
      wait_done(1'b0);
      check("store_stall_cycles", 64'(stall_cnt - s0), 64'(LATENCY));
      s0 = stall_cnt;
      issue(1'b0, 16'h0005, 32'h0, 1'b0, 1'b1);
      wait_done(1'b0);
      check("load_stall_cycles", 64'(stall_cnt - s0), 64'(LATENCY));

      // 3. Response backpressure
      bus.resp_ready = 1'b0;
      issue(1'b0, 16'h0005, 32'h0, 1'b0, 1'b1);
      begin
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
               seen = 1'b1;
               break;
            end
         end
         if (!seen) timeout("bp_resp_valid");
      end
      for (int i = 0; i < 5; i++) begin
         if (i != 0) @(negedge clk);
         check("bp_resp_valid", 64'(bus.resp_valid), 64'd1);
         check("bp_resp_rdata", 64'(bus.resp_rdata), 64'h00000000DEADBEEF);
         check("bp_stall",      64'(bus.stall),      64'd1);
         check("bp_req_ready",  64'(bus.req_ready),  64'd0);
      end
      @(posedge clk); #1;
      bus.resp_ready = 1'b1;
      @(negedge clk);
      check("bp_release_stall", 64'(bus.stall), 64'd0);
      @(negedge clk);
      check("bp_idle_req_ready",  64'(bus.req_ready),  64'd1);
      check("bp_idle_resp_valid", 64'(bus.resp_valid), 64'd0);
      @(posedge clk); #1;

      // 4. Out-of-range store is dropped
      issue(1'b1, 16'h0400, 32'h12345678, 1'b0, 1'b1);
      wait_done(1'b0);
      issue(1'b0, 16'h0000, 32'h0, 1'b0, 1'b1);
      wait_done(1'b0);

      // 5. Reset during WAIT drops the store and the response
      issue(1'b1, 16'h0003, 32'hAAAA5555, 1'b0, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("midrst_resp_valid", 64'(bus.resp_valid), 64'd0);
         check("midrst_req_ready",  64'(bus.req_ready),  64'd1);
      end
      @(posedge clk); #1;
      issue(1'b0, 16'h0003, 32'h0, 1'b0, 1'b1);
      wait_done(1'b0);

      // 6. Parity injection (resp_err on the load only with DMEM_PARITY_EN)
      issue(1'b1, 16'h0007, 32'h00000001, 1'b1, 1'b1);
      wait_done(1'b0);
      issue(1'b0, 16'h0007, 32'h0, 1'b0, 1'b1);
      wait_done(1'b0);

      // Random traffic with random backpressure and idle gaps
      for (int n = 0; n < 150; n++) begin
         wr = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0)
            a = 16'(($urandom_range(1, 63) << ADDR_W) | $urandom_range(0, 15));
         else
            a = 16'($urandom_range(0, 15));
         d = $urandom;
         bus.resp_ready = 1'($urandom_range(0, 1));
         issue(wr, a, d, ($urandom_range(0, 3) == 0), 1'b1);
         wait_done(1'b1);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      bus.resp_ready = 1'b1;

      repeat (4) @(posedge clk);
      check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the slave end of the pipeline MEMORY stage's load/store interface.
- Accepts one read or write request at a time over a valid/ready handshake and services it from an internal word-addressed RAM after a fixed, parameterised latency.
- Returns the response over a valid/ready handshake and drives a stall that freezes the pipeline while a request is outstanding.
- Sits beside the memory stage and replaces its zero-latency array.

Parameters:
- ADDR_W, 10, RAM word-address width; depth = 2**ADDR_W words.
- DATA_W, 32, data word width; matches the pipeline's 32-bit register data.
- LATENCY, 2, cycles from request accept to resp_valid; legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present; requester holds all req_* stable until accepted.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  16  word address from the ALU result (low 16 bits).
- req_wdata  in  DATA_W  store data.
- req_ready  out  1  responder can accept this cycle.
- resp_valid  out  1  response available.
- resp_ready  in  1  requester consumes the response this cycle.
- resp_rdata  out  DATA_W  load data, or echoed store data.
- resp_err  out  1  address out of range (or parity error, see Optional Feature).
- stall  out  1  pipeline freeze request.
- perr_inject  in  1  test-only: corrupt stored parity on a write; ignored without the macro.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE; latency counter = 0; the captured request is cleared.
  - After reset: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - RAM contents are not cleared.
  - A reset mid-operation drops any uncommitted write and any pending response.
- States:
  - IDLE: req_ready=1. On req_valid, capture write/addr/wdata; counter = LATENCY-1. Go to RESP if LATENCY==1, else WAIT.
  - WAIT: req_ready=0. Counter decrements each cycle; when counter==1 on a clock edge, go to RESP.
  - RESP: req_ready=0, resp_valid=1; resp_rdata and resp_err held stable. On resp_ready, go to IDLE.
- Latency:
  - Request accepted at edge N gives resp_valid=1 from cycle N+LATENCY onward.
  - With resp_ready held high, a request completes in LATENCY+1 cycles including the IDLE accept cycle.
  - No back-to-back overlap; the next accept is in the IDLE cycle after the RESP handshake.
- Commit:
  - The RAM access (read or write) happens on the edge that enters RESP.
  - Reads return RAM contents as of that edge.
- Address range:
  - req_addr[15:ADDR_W] != 0 → resp_err=1, write suppressed, resp_rdata=0.
  - With ADDR_W=16 there is no range check.
- Store response: resp_rdata = captured wdata, resp_err per the range check.
- stall = (IDLE & req_valid) | WAIT | (RESP & ~resp_ready). Combinational; low in the RESP cycle that completes the handshake.
- Inputs while not in IDLE:
  - req_valid is ignored; it must be held by the requester.
  - A req_* change while unaccepted is a protocol violation and the behaviour is undefined.
- resp_ready outside RESP is ignored.
- Counter is 4 bits wide.
- LATENCY outside 1..15 is an elaboration error (generate-time check).

Optional Feature:
- Macro: DMEM_PARITY_EN.
- Defined:
  - Each RAM word stores one extra even-parity bit, computed over wdata at commit.
  - If perr_inject=1 when the write is captured, the stored parity bit is inverted.
  - A load recomputes parity. On mismatch, resp_err=1, while resp_rdata still carries the raw stored data.
  - A range error also sets resp_err.
- Undefined:
  - No parity storage.
  - perr_inject is unused.
  - resp_err reflects the range check only.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles → req_ready=1, resp_valid=0, resp_rdata=0, stall=0.
2. Store then load, LATENCY=2, resp_ready=1:
   - Write addr 0x0005 data 0xDEADBEEF → resp_valid exactly 2 cycles after accept, resp_rdata=0xDEADBEEF.
   - Read addr 0x0005 → resp_rdata=0xDEADBEEF, resp_err=0.
   - stall is high for 2 cycles per request.
3. Response backpressure: hold resp_ready=0 for 5 cycles in RESP → resp_valid and resp_rdata stable, stall=1, req_ready=0. resp_ready=1 → IDLE next cycle, stall drops the same cycle.
4. Out of range, ADDR_W=10: write 0x0400 data 0x12345678 → resp_err=1. Read 0x0000 (previously 0) → still 0, proving the write was dropped.
5. Reset mid-WAIT: write addr 3 data 0xAAAA5555, assert rst in the WAIT cycle → IDLE, no resp_valid. Read addr 3 → prior contents returned.
6. With DMEM_PARITY_EN: write addr 7 data 0x1 with perr_inject=1, then read addr 7 → resp_rdata=0x1, resp_err=1. Without the macro, the same sequence gives resp_err=0.
